// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with IDLE/FETCH/HOLD/TRAP FSM.
// Presents one fetched word to decode and selects the next PC from JALR/JAL/branch/sequential.
// Optional build macro: FETCH_MISALIGN_TRAP_EN -- a misaligned next PC traps (sticky
// misalign_err, FSM parks in TRAP until reset). Without it, next-PC bits [1:0] are cleared.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        en_branch,
  input  logic        Jump,
  input  logic        Jalr,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        w_fetch_done;
  logic        w_handoff;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic        w_misalign;
  logic        w_unused_bits;

  // Only an ack seen while fetching completes a request; only an accepted
  // instruction in HOLD may redirect the PC.
  assign w_fetch_done = (r_state == FETCH) && imem_ack;
  assign w_handoff    = (r_state == HOLD) && instr_ready;

  // Next-PC priority: JALR (LSB cleared) over JAL/taken branch over sequential.
  always_comb begin
    w_target = r_pc + 32'd4;
    if (Jalr) begin
      w_target = {jalr_target[31:1], 1'b0};
    end else if (Jump || en_branch) begin
      w_target = branch_target;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Keep the offending address so it can be inspected in TRAP.
  assign w_misalign = (w_target[1:0] != 2'b00);
  assign w_next_pc  = w_target;
`else
  // Word-align silently; a trap can never be requested.
  assign w_misalign = 1'b0;
  assign w_next_pc  = {w_target[31:2], 2'b00};
`endif

  // Bits that are dropped by construction in some builds.
  assign w_unused_bits = ^{jalr_target[0], w_target[1:0]};

  // FSM state register; reset forces IDLE at once, abandoning any open request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  w_state_next = FETCH;
      FETCH: if (imem_ack) w_state_next = HOLD;
      HOLD: begin
        if (instr_ready) begin
          w_state_next = w_misalign ? TRAP : FETCH;
        end
      end
      TRAP:    w_state_next = TRAP;
      default: w_state_next = IDLE;
    endcase
  end

  // PC advances only when decode accepts the presented instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_handoff) begin
      r_pc <= w_next_pc;
    end
  end

  // Capture the fetched word and track whether it is being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr       <= NOP;
      r_instr_valid <= 1'b0;
    end else if (w_fetch_done) begin
      r_instr       <= imem_rdata;
      r_instr_valid <= 1'b1;
    end else if (w_handoff) begin
      r_instr_valid <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign_err;

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign_err <= 1'b0;
    end else if (w_handoff && w_misalign) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign misalign_err = r_misalign_err;
`else
  assign misalign_err = 1'b0;
`endif

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus a
// transaction-level model checked every cycle on the falling edge.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] SALT     = 32'hA5A5_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        en_branch = 1'b0;
  logic        Jump = 1'b0;
  logic        Jalr = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] jalr_target = 32'h0;
  logic        misalign_err;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int rel_cyc  = 0;

  // Memory returns an address-derived word so each fetch is distinguishable.
  assign imem_rdata = imem_addr ^ SALT;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_plus4(pc_plus4),
    .en_branch(en_branch), .Jump(Jump), .Jalr(Jalr),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------------
  logic [31:0] m_addr = RESET_PC;
  logic [31:0] m_instr = NOP;
  logic        m_exp_valid = 1'b0;
  logic        m_exp_drop = 1'b0;
  logic        m_req_next = 1'b0;
  logic        m_trap = 1'b0;

  always @(negedge clk) begin
    logic [31:0] t;
    if (!rst_n) begin
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_instr", instr, NOP);
      chk("rst_misalign", misalign_err, 0);
      m_addr = RESET_PC; m_instr = NOP; m_exp_valid = 0;
      m_exp_drop = 0; m_req_next = 0; m_trap = 0;
    end else begin
      if (m_exp_valid) chk("m_valid_after_ack", instr_valid, 1);
      if (m_exp_drop)  chk("m_valid_drop", instr_valid, 0);
      if (m_req_next)  chk("m_req_expected", imem_req, 1);
      chk("m_misalign", misalign_err, m_trap);
      if (m_trap) begin
        chk("m_trap_req", imem_req, 0);
        chk("m_trap_valid", instr_valid, 0);
        chk("m_trap_pc", pc, m_addr);
      end
      if (imem_req) begin
        chk("m_fetch_addr", imem_addr, m_addr);
        chk("m_fetch_pc", pc, m_addr);
        chk("m_fetch_valid", instr_valid, 0);
      end
      if (instr_valid) begin
        chk("m_instr", instr, m_instr);
        chk("m_pc", pc, m_addr);
        chk("m_pc_plus4", pc_plus4, m_addr + 32'd4);
        chk("m_hold_req", imem_req, 0);
      end
      // Predict what the next cycle must show.
      m_exp_valid = imem_req && imem_ack;
      if (imem_req && imem_ack) m_instr = imem_rdata;
      m_req_next = imem_req && !imem_ack;
      m_exp_drop = instr_valid && instr_ready;
      if (instr_valid && instr_ready) begin
        if (Jalr)                   t = {jalr_target[31:1], 1'b0};
        else if (Jump || en_branch) t = branch_target;
        else                        t = m_addr + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) m_trap = 1'b1;
        m_addr = t;
`else
        m_addr = {t[31:2], 2'b00};
`endif
        if (!m_trap) m_req_next = 1'b1;
      end
    end
  end

  // Log of completed fetches for throughput/ordering checks.
  logic [31:0] log_addr[$];
  int          log_cyc[$];
  always @(negedge clk) begin
    if (rst_n && imem_req && imem_ack) begin
      log_addr.push_back(imem_addr);
      log_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) seen = 1;
    end
    if (!seen) chk(name, 0, 1);
  endtask

  // From HOLD with ready=0/ack=0: redirect to addr, fetch it, land in HOLD there.
  task automatic goto_hold(input logic [31:0] addr);
    instr_ready = 1; en_branch = 1; branch_target = addr;
    tick();
    instr_ready = 0; en_branch = 0; branch_target = 0; imem_ack = 1;
    tick();
    imem_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // T1: ack and ready every cycle -> 0x0, 0x4, 0x8 two cycles apart after one IDLE cycle.
    imem_ack = 1; instr_ready = 1;
    log_addr.delete(); log_cyc.delete();
    do_reset();
    @(negedge clk);
    chk("t1_idle_req", imem_req, 0);
    repeat (6) tick();
    chk("t1_fetch_count", (log_addr.size() >= 3) ? 1 : 0, 1);
    for (int i = 0; i < 3; i++) begin
      if (i < log_addr.size()) begin
        chk($sformatf("t1_addr%0d", i), log_addr[i], 32'(4 * i));
        chk($sformatf("t1_cyc%0d", i), 32'(log_cyc[i] - rel_cyc), 32'(1 + 2 * i));
      end
    end

    // T2: ack delayed 3 cycles at 0x10.
    instr_ready = 0;
    wait_valid("t2_wait_hold");
    tick();
    imem_ack = 0; instr_ready = 1; en_branch = 1; branch_target = 32'h10;
    tick();
    instr_ready = 0; en_branch = 0; branch_target = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t2_req%0d", k), imem_req, 1);
      chk($sformatf("t2_addr%0d", k), imem_addr, 32'h10);
      tick();
      if (k == 2) imem_ack = 1;
    end
    imem_ack = 0;
    @(negedge clk);
    chk("t2_valid", instr_valid, 1);
    chk("t2_instr", instr, 32'hA5A5_0003);
    chk("t2_pc", pc, 32'h10);
    chk("t2_pc_plus4", pc_plus4, 32'h14);

    // T3: branch held while ready=0 is ignored, taken once ready=1.
    tick();
    goto_hold(32'h20);
    en_branch = 1; branch_target = 32'h100;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_valid%0d", k), instr_valid, 1);
      chk($sformatf("t3_hold_pc%0d", k), pc, 32'h20);
      chk($sformatf("t3_hold_req%0d", k), imem_req, 0);
      tick();
    end
    instr_ready = 1;
    tick();
    en_branch = 0; branch_target = 0; instr_ready = 0;
    @(negedge clk);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h100);
    tick(); imem_ack = 1;
    tick(); imem_ack = 0;

    // T4: JALR beats JAL, LSB cleared.
    Jalr = 1; Jump = 1; jalr_target = 32'h205; branch_target = 32'h300; instr_ready = 1;
    tick();
    Jalr = 0; Jump = 0; jalr_target = 0; branch_target = 0; instr_ready = 0;
    @(negedge clk);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h204);
    tick(); imem_ack = 1;
    tick(); imem_ack = 0;

    // T5: misaligned branch target.
    en_branch = 1; branch_target = 32'h102; instr_ready = 1;
    tick();
    en_branch = 0; branch_target = 0; instr_ready = 0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t5_misalign", misalign_err, 1);
    chk("t5_pc", pc, 32'h102);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_trap_req%0d", k), imem_req, 0);
      tick();
      imem_ack = 1;
      @(negedge clk);
    end
    imem_ack = 0;
`else
    chk("t5_misalign", misalign_err, 0);
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 32'h100);
`endif

    // T6: reset mid-FETCH at 0x40, ack during reset/IDLE ignored.
    tick();
    imem_ack = 0; instr_ready = 0;
    do_reset();
    tick(); imem_ack = 1;
    tick(); imem_ack = 0;
    instr_ready = 1; en_branch = 1; branch_target = 32'h40;
    tick();
    instr_ready = 0; en_branch = 0; branch_target = 0;
    @(negedge clk);
    chk("t6_req_before", imem_req, 1);
    chk("t6_addr_before", imem_addr, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_async", imem_req, 0);
    chk("t6_pc_async", pc, RESET_PC);
    chk("t6_instr_async", instr, NOP);
    tick();
    imem_ack = 1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_req", imem_req, 0);
    chk("t6_idle_valid", instr_valid, 0);
    tick();
    imem_ack = 0;
    @(negedge clk);
    chk("t6_refetch_req", imem_req, 1);
    chk("t6_refetch_addr", imem_addr, RESET_PC);
    chk("t6_refetch_valid", instr_valid, 0);
    tick(); imem_ack = 1;
    tick(); imem_ack = 0;
    @(negedge clk);
    chk("t6_valid", instr_valid, 1);
    chk("t6_instr", instr, 32'hA5A5_0013);
    chk("t6_pc", pc, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
